// File: rtl/time_setter.sv
// time_setter: button-driven hour/minute/second editor for the clock block.
// Ports: clk, rst, btn_* (mode/inc/dec/cancel), cur_* in, *_modified/modify/hold/field_sel out.
module time_setter #(
  parameter int HOUR   = 5,
  parameter int MINUTE = 3,
  parameter int SECOND = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_cancel,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_second,
  output logic [7:0] cur_hour_modified,
  output logic [7:0] cur_minute_modified,
  output logic [7:0] cur_second_modified,
  output logic       modify,
  output logic       hold,
  output logic [1:0] field_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOUR,
    S_MIN,
    S_SEC,
    S_COMMIT
  } state_t;

  localparam logic [7:0] LP_H = HOUR[7:0];
  localparam logic [7:0] LP_M = MINUTE[7:0];
  localparam logic [7:0] LP_S = SECOND[7:0];

  state_t     r_state;
  logic       r_mode_q;
  logic       r_inc_q;
  logic       r_dec_q;
  logic       r_cancel_q;
  logic [7:0] r_hour;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_modify;
  logic       r_hold;
  logic [1:0] r_field_sel;

  logic w_mode;
  logic w_inc;
  logic w_dec;
  logic w_cancel;
  logic w_step;

  assign w_mode   = btn_mode & ~r_mode_q;
  assign w_inc    = btn_inc & ~r_inc_q;
  assign w_dec    = btn_dec & ~r_dec_q;
  assign w_cancel = btn_cancel & ~r_cancel_q;
  // inc and dec together cancel out
  assign w_step   = w_inc ^ w_dec;

  function automatic logic [7:0] f_adj(
    input logic [7:0] v,
    input logic [7:0] n,
    input logic       up
  );
    if (up) return (v == n - 8'd1) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0) ? n - 8'd1 : v - 8'd1;
  endfunction

  function automatic logic [7:0] f_clamp(
    input logic [7:0] v,
    input logic [7:0] n
  );
    return (v >= n) ? 8'd0 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      // prev regs start high so a button held through reset is not an edge
      r_mode_q    <= 1'b1;
      r_inc_q     <= 1'b1;
      r_dec_q     <= 1'b1;
      r_cancel_q  <= 1'b1;
      r_hour      <= 8'd0;
      r_min       <= 8'd0;
      r_sec       <= 8'd0;
      r_modify    <= 1'b0;
      r_hold      <= 1'b0;
      r_field_sel <= 2'd0;
    end else begin
      r_mode_q   <= btn_mode;
      r_inc_q    <= btn_inc;
      r_dec_q    <= btn_dec;
      r_cancel_q <= btn_cancel;
      unique case (r_state)
        S_IDLE: begin
          if (w_mode) begin
            r_state     <= S_HOUR;
            r_hold      <= 1'b1;
            r_field_sel <= 2'd1;
            r_hour      <= f_clamp(cur_hour, LP_H);
            r_min       <= f_clamp(cur_minute, LP_M);
            r_sec       <= f_clamp(cur_second, LP_S);
          end
        end
        S_HOUR: begin
          if (w_cancel) begin
            r_state     <= S_IDLE;
            r_hold      <= 1'b0;
            r_field_sel <= 2'd0;
          end else if (w_mode) begin
            r_state     <= S_MIN;
            r_field_sel <= 2'd2;
          end else if (w_step) begin
            r_hour <= f_adj(r_hour, LP_H, w_inc);
          end
        end
        S_MIN: begin
          if (w_cancel) begin
            r_state     <= S_IDLE;
            r_hold      <= 1'b0;
            r_field_sel <= 2'd0;
          end else if (w_mode) begin
            r_state     <= S_SEC;
            r_field_sel <= 2'd3;
          end else if (w_step) begin
            r_min <= f_adj(r_min, LP_M, w_inc);
          end
        end
        S_SEC: begin
          if (w_cancel) begin
            r_state     <= S_IDLE;
            r_hold      <= 1'b0;
            r_field_sel <= 2'd0;
          end else if (w_mode) begin
            r_state     <= S_COMMIT;
            r_modify    <= 1'b1;
            r_field_sel <= 2'd0;
          end else if (w_step) begin
            r_sec <= f_adj(r_sec, LP_S, w_inc);
          end
        end
        S_COMMIT: begin
          r_state  <= S_IDLE;
          r_modify <= 1'b0;
          r_hold   <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_modify    <= 1'b0;
          r_hold      <= 1'b0;
          r_field_sel <= 2'd0;
        end
      endcase
    end
  end

  assign cur_hour_modified   = r_hour;
  assign cur_minute_modified = r_min;
  assign cur_second_modified = r_sec;
  assign modify              = r_modify;
  assign hold                = r_hold;
  assign field_sel           = r_field_sel;

endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: directed self-checking bench for time_setter.
// Inputs change 1 time unit after posedge; outputs are checked there too.
module tb_time_setter;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_cancel;
  logic [7:0] cur_hour;
  logic [7:0] cur_minute;
  logic [7:0] cur_second;
  logic [7:0] hour_mod;
  logic [7:0] min_mod;
  logic [7:0] sec_mod;
  logic       modify;
  logic       hold;
  logic [1:0] field_sel;

  int checks;
  int failures;
  int mod_cnt;
  int snap;

  time_setter #(
    .HOUR(5),
    .MINUTE(3),
    .SECOND(21)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .btn_mode           (btn_mode),
    .btn_inc            (btn_inc),
    .btn_dec            (btn_dec),
    .btn_cancel         (btn_cancel),
    .cur_hour           (cur_hour),
    .cur_minute         (cur_minute),
    .cur_second         (cur_second),
    .cur_hour_modified  (hour_mod),
    .cur_minute_modified(min_mod),
    .cur_second_modified(sec_mod),
    .modify             (modify),
    .hold               (hold),
    .field_sel          (field_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (modify === 1'b1) mod_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic i,
                       input logic d, input logic c);
    btn_mode   = m;
    btn_inc    = i;
    btn_dec    = d;
    btn_cancel = c;
    step();
  endtask

  task automatic rel();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s);
    cur_hour   = h;
    cur_minute = m;
    cur_second = s;
  endtask

  task automatic test_reset();
    btn_mode = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({modify, hold, field_sel} !== 4'b0) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=0000", {modify, hold, field_sel});
    end
    checks++;
    if ({hour_mod, min_mod, sec_mod} !== 24'd0) begin
      failures++;
      $display("FAIL rst_fields got=%h exp=000000",
               {hour_mod, min_mod, sec_mod});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (hold !== 1'b0 || field_sel !== 2'd0) begin
      failures++;
      $display("FAIL rst_held_edge hold=%b sel=%0d exp=0/0", hold, field_sel);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hold !== 1'b1 || field_sel !== 2'd1) begin
      failures++;
      $display("FAIL rst_new_edge hold=%b sel=%0d exp=1/1", hold, field_sel);
    end
    rel();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    rel();
    checks++;
    if (hold !== 1'b0) begin
      failures++;
      $display("FAIL rst_cancel hold=%b exp=0", hold);
    end
  endtask

  task automatic test_full_edit();
    set_cur(8'd3, 8'd1, 8'd20);
    snap = mod_cnt;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hold !== 1'b1 || field_sel !== 2'd1 ||
        {hour_mod, min_mod, sec_mod} !== {8'd3, 8'd1, 8'd20}) begin
      failures++;
      $display("FAIL fe_capture hold=%b sel=%0d h/m/s=%0d/%0d/%0d exp=1 1 3/1/20",
               hold, field_sel, hour_mod, min_mod, sec_mod);
    end
    rel();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    rel();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (hour_mod !== 8'd1) begin
      failures++;
      $display("FAIL fe_dec2 hour=%0d exp=1", hour_mod);
    end
    rel();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (field_sel !== 2'd2 || min_mod !== 8'd2 || hold !== 1'b1) begin
      failures++;
      $display("FAIL fe_min sel=%0d min=%0d hold=%b exp=2 2 1",
               field_sel, min_mod, hold);
    end
    rel();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (field_sel !== 2'd3 || sec_mod !== 8'd0 || modify !== 1'b0) begin
      failures++;
      $display("FAIL fe_sec sel=%0d sec=%0d mod=%b exp=3 0 0",
               field_sel, sec_mod, modify);
    end
    rel();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (modify !== 1'b1 || hold !== 1'b1 || field_sel !== 2'd0 ||
        {hour_mod, min_mod, sec_mod} !== {8'd1, 8'd2, 8'd0}) begin
      failures++;
      $display("FAIL fe_commit mod=%b hold=%b sel=%0d h/m/s=%0d/%0d/%0d exp=1 1 0 1/2/0",
               modify, hold, field_sel, hour_mod, min_mod, sec_mod);
    end
    rel();
    checks++;
    if (modify !== 1'b0 || hold !== 1'b0 ||
        {hour_mod, min_mod, sec_mod} !== {8'd1, 8'd2, 8'd0}) begin
      failures++;
      $display("FAIL fe_after mod=%b hold=%b h/m/s=%0d/%0d/%0d exp=0 0 1/2/0",
               modify, hold, hour_mod, min_mod, sec_mod);
    end
    step();
    checks++;
    if (mod_cnt - snap !== 1) begin
      failures++;
      $display("FAIL fe_modcnt got=%0d exp=1", mod_cnt - snap);
    end
  endtask

  task automatic test_wrap_clamp();
    set_cur(8'd7, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hour_mod !== 8'd0) begin
      failures++;
      $display("FAIL wc_clamp hour=%0d exp=0", hour_mod);
    end
    rel();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (hour_mod !== 8'd4) begin
      failures++;
      $display("FAIL wc_dec_wrap hour=%0d exp=4", hour_mod);
    end
    rel();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (hour_mod !== 8'd0) begin
      failures++;
      $display("FAIL wc_inc_wrap hour=%0d exp=0", hour_mod);
    end
    rel();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (min_mod !== 8'd2) begin
      failures++;
      $display("FAIL wc_min_wrap min=%0d exp=2", min_mod);
    end
    rel();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    rel();
  endtask

  task automatic test_cancel();
    set_cur(8'd1, 8'd1, 8'd1);
    snap = mod_cnt;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (hold !== 1'b0 || field_sel !== 2'd0 || min_mod !== 8'd1 ||
        hour_mod !== 8'd1 || modify !== 1'b0) begin
      failures++;
      $display("FAIL cancel hold=%b sel=%0d min=%0d hour=%0d mod=%b exp=0 0 1 1 0",
               hold, field_sel, min_mod, hour_mod, modify);
    end
    rel();
    step();
    checks++;
    if (mod_cnt - snap !== 0 || hold !== 1'b0) begin
      failures++;
      $display("FAIL cancel_nomod cnt=%0d hold=%b exp=0 0", mod_cnt - snap, hold);
    end
  endtask

  task automatic test_simultaneous();
    set_cur(8'd2, 8'd0, 8'd5);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (hour_mod !== 8'd2) begin
      failures++;
      $display("FAIL sim_incdec hour=%0d exp=2", hour_mod);
    end
    rel();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (field_sel !== 2'd2 || hour_mod !== 8'd2 || min_mod !== 8'd0) begin
      failures++;
      $display("FAIL sim_modeinc sel=%0d hour=%0d min=%0d exp=2 2 0",
               field_sel, hour_mod, min_mod);
    end
    rel();
    btn_mode = 1'b1;
    repeat (10) step();
    checks++;
    if (field_sel !== 2'd3 || modify !== 1'b0) begin
      failures++;
      $display("FAIL sim_held sel=%0d mod=%b exp=3 0", field_sel, modify);
    end
    rel();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (modify !== 1'b1) begin
      failures++;
      $display("FAIL b2b_commit mod=%b exp=1", modify);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (field_sel !== 2'd1 || hold !== 1'b1 || modify !== 1'b0) begin
      failures++;
      $display("FAIL b2b_recapture sel=%0d hold=%b mod=%b exp=1 1 0",
               field_sel, hold, modify);
    end
    rel();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    rel();
  endtask

  task automatic test_reset_mid_edit();
    set_cur(8'd2, 8'd1, 8'd3);
    snap = mod_cnt;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rel();
    checks++;
    if (field_sel !== 2'd3) begin
      failures++;
      $display("FAIL rm_in_sec sel=%0d exp=3", field_sel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (modify !== 1'b0 || hold !== 1'b0 || field_sel !== 2'd0 ||
        {hour_mod, min_mod, sec_mod} !== 24'd0) begin
      failures++;
      $display("FAIL rm_async mod=%b hold=%b sel=%0d h/m/s=%0d/%0d/%0d exp=0 0 0 0/0/0",
               modify, hold, field_sel, hour_mod, min_mod, sec_mod);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    checks++;
    if (hold !== 1'b0 || mod_cnt - snap !== 0) begin
      failures++;
      $display("FAIL rm_after hold=%b modcnt=%0d exp=0 0", hold, mod_cnt - snap);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    mod_cnt    = 0;
    snap       = 0;
    rst        = 1'b0;
    btn_mode   = 1'b0;
    btn_inc    = 1'b0;
    btn_dec    = 1'b0;
    btn_cancel = 1'b0;
    set_cur(8'd0, 8'd0, 8'd0);
    test_reset();
    test_full_edit();
    test_wrap_clamp();
    test_cancel();
    test_simultaneous();
    test_reset_mid_edit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
